// File: rtl/mult_share_arbiter.sv
// Two requester FIFOs share one pipelined 8x8 multiplier and a credit-guarded output FIFO.
// Define ARB_STATS_EN to add per-requester write counters CNT0/CNT1 with synchronous CNT_CLR.
module mult_share_arbiter #(
    parameter int OUT_DEPTH = 1024,
    parameter int MULT_LAT  = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STOP,
    input  logic        REQ0_EMPTY,
    input  logic        REQ0_VALID,
    input  logic [15:0] REQ0_DIN,
    output logic        REQ0_RD,
    input  logic        REQ1_EMPTY,
    input  logic        REQ1_VALID,
    input  logic [15:0] REQ1_DIN,
    output logic        REQ1_RD,
    input  logic        OUT_RD,
    output logic        OUT_WR,
    output logic [16:0] OUT_DOUT,
    output logic        BUSY,
    output logic        ERR
`ifdef ARB_STATS_EN
    ,
    input  logic        CNT_CLR,
    output logic [15:0] CNT0,
    output logic [15:0] CNT1
`endif
);
    localparam int CW = $clog2(OUT_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(OUT_DEPTH);
    localparam logic [CW:0] FULL_X = {1'b0, FULL};

    logic [CW-1:0] credit_q, credit_d;
    logic [CW:0]   credit_sum;
    logic          last_grant_q, last_grant_d;
    logic          slot_vld_q, slot_vld_d;
    logic          slot_tag_q, slot_tag_d;
    logic          ret_q, ret_d;
    logic          err_q, err_d;
    logic [MULT_LAT-1:0]       stg_vld_q, stg_vld_d;
    logic [MULT_LAT-1:0]       stg_tag_q, stg_tag_d;
    logic [MULT_LAT-1:0][15:0] stg_prod_q, stg_prod_d;

    logic        issue, grant;
    logic        cap_valid;
    logic [15:0] cap_din;

    // Read strobes stay combinational so an empty FIFO is never read and reset blocks issue.
    always_comb begin
        issue   = RST && !STOP && (credit_q != '0) && (!REQ0_EMPTY || !REQ1_EMPTY);
        grant   = (!REQ0_EMPTY && !REQ1_EMPTY) ? !last_grant_q : !REQ1_EMPTY;
        REQ0_RD = issue && !grant;
        REQ1_RD = issue && grant;
    end

    always_comb begin
        cap_din       = slot_tag_q ? REQ1_DIN : REQ0_DIN;
        cap_valid     = slot_tag_q ? REQ1_VALID : REQ0_VALID;
        last_grant_d  = issue ? grant : last_grant_q;
        slot_vld_d    = issue;
        slot_tag_d    = grant;
        ret_d         = slot_vld_q && !cap_valid;
        err_d         = err_q || ret_d;
        stg_vld_d     = stg_vld_q;
        stg_tag_d     = stg_tag_q;
        stg_prod_d    = stg_prod_q;
        stg_vld_d[0]  = slot_vld_q && cap_valid;
        stg_tag_d[0]  = slot_tag_q;
        stg_prod_d[0] = {8'h00, cap_din[15:8]} * {8'h00, cap_din[7:0]};
        for (int i = 1; i < MULT_LAT; i++) begin
            stg_vld_d[i]  = stg_vld_q[i-1];
            stg_tag_d[i]  = stg_tag_q[i-1];
            stg_prod_d[i] = stg_prod_q[i-1];
        end
        // A dropped slot hands its credit back one cycle later, alongside any consumer read.
        credit_sum = {1'b0, credit_q} + {{CW{1'b0}}, OUT_RD} + {{CW{1'b0}}, ret_q}
                   - {{CW{1'b0}}, issue};
        credit_d   = (credit_sum > FULL_X) ? FULL : credit_sum[CW-1:0];
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            credit_q     <= FULL;
            last_grant_q <= 1'b1;
            slot_vld_q   <= 1'b0;
            slot_tag_q   <= 1'b0;
            ret_q        <= 1'b0;
            err_q        <= 1'b0;
            stg_vld_q    <= '0;
            stg_tag_q    <= '0;
            stg_prod_q   <= '0;
        end else begin
            credit_q     <= credit_d;
            last_grant_q <= last_grant_d;
            slot_vld_q   <= slot_vld_d;
            slot_tag_q   <= slot_tag_d;
            ret_q        <= ret_d;
            err_q        <= err_d;
            stg_vld_q    <= stg_vld_d;
            stg_tag_q    <= stg_tag_d;
            stg_prod_q   <= stg_prod_d;
        end
    end

    assign OUT_WR   = stg_vld_q[MULT_LAT-1];
    assign OUT_DOUT = {stg_tag_q[MULT_LAT-1], stg_prod_q[MULT_LAT-1]};
    assign BUSY     = slot_vld_q || (|stg_vld_q);
    assign ERR      = err_q;

`ifdef ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Clear wins over a same-cycle increment; counters wrap naturally.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (CNT_CLR) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (OUT_WR) begin
            if (OUT_DOUT[16]) cnt1_d = cnt1_q + 16'd1;
            else              cnt0_d = cnt0_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign CNT0 = cnt0_q;
    assign CNT1 = cnt1_q;
`endif
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 8x8 multiplier and one output FIFO between two input FIFOs (requester 0, requester 1).
- Sequences FIFO reads with round-robin arbitration and runs operands through a MULT_LAT-stage multiplier pipeline.
- Writes each tagged product into the output FIFO, using credits so the output FIFO never overflows.
- Sits between two producer FIFOs and the consumer-side FIFO; drives every RD/WR strobe in that path.

Parameters:
- OUT_DEPTH, 1024, output FIFO capacity in words; initial credit value.
- MULT_LAT, 2, multiplier register stages after operand capture; legal range 1..4.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-low (0 = reset).
- STOP  input  1  1 = issue no new reads; in-flight work still drains.
- REQ0_EMPTY  input  1  requester 0 FIFO empty.
- REQ0_VALID  input  1  requester 0 read data valid.
- REQ0_DIN  input  16  requester 0 read data; [15:8] = operand A, [7:0] = operand B.
- REQ0_RD  output  1  requester 0 FIFO read strobe.
- REQ1_EMPTY, REQ1_VALID, REQ1_DIN, REQ1_RD: same as requester 0, for requester 1.
- OUT_RD  input  1  consumer read strobe on the output FIFO; returns one credit.
- OUT_WR  output  1  output FIFO write strobe.
- OUT_DOUT  output  17  output FIFO write data; [16] = source requester, [15:0] = unsigned A*B.
- BUSY  output  1  1 while any operation is in flight.
- ERR  output  1  sticky flag: an expected VALID did not arrive.

Behaviour:
- Reset (RST=0 at an edge):
  - REQ0_RD, REQ1_RD, OUT_WR, BUSY, ERR = 0; OUT_DOUT = 0.
  - credit = OUT_DEPTH; pipeline valids cleared; last_grant = 1, so requester 0 wins first.
  - Reset mid-operation discards all in-flight operations; the output FIFO must be reset in the same cycle.
- Issue condition, evaluated each cycle: RST=1, STOP=0, credit>0, and at least one REQn_EMPTY=0.
- Grant and read:
  - Exactly one RD pulse per issuing cycle; RD is combinational from the registered state and the current EMPTY flags.
  - Never assert both RD outputs, and never assert RD while that requester's EMPTY=1.
- Arbitration:
  - Both requesters ready: grant the one that is not last_grant.
  - One requester ready: grant it, whatever last_grant is.
  - last_grant updates only on an issue.
- Credit counter, width clog2(OUT_DEPTH)+1 bits:
  - Decrements on issue; increments on OUT_RD.
  - Issue and OUT_RD in the same cycle: credit unchanged.
  - credit never exceeds OUT_DEPTH; an OUT_RD at full credit is ignored.
- Read latency: FIFO data arrives 1 cycle after RD (cycle t+1) with VALID=1.
  - The grant tag is delayed 1 cycle to align with the data.
  - Operands and tag are captured at t+1, then pass through MULT_LAT register stages.
- Write: OUT_WR=1 at cycle t+1+MULT_LAT, with OUT_DOUT = {tag, A*B}.
  - Pipeline is fully pipelined: 1 issue/cycle gives 1 write/cycle.
- Missing data: if the expected VALID is 0 at t+1:
  - Drop the slot (no OUT_WR), return its credit the following cycle, set ERR=1.
  - ERR clears only on reset.
- STOP:
  - Takes effect in the same cycle: no RD while STOP=1.
  - Operations already issued still complete and write.
- BUSY = OR of the read-latency slot and all pipeline stage valids.
- Arithmetic: unsigned 8x8 → 16 bits, no overflow possible; 0xFF*0xFF = 0xFE01.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs CNT0 and CNT1, 16 bits each.
  - Each counts OUT_WR writes from its requester; wraps 0xFFFF→0x0000; 0 at reset.
  - Adds input CNT_CLR: synchronous clear of both counters, which takes priority over an increment in the same cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single-request latency: reset, then requester 0 holds one word 0x0304 → REQ0_RD for 1 cycle; OUT_WR 3 cycles later (MULT_LAT=2) with OUT_DOUT=0x0000C; BUSY high for those 3 cycles.
- Round-robin fairness: both FIFOs hold 4 words (req0 0x0202, req1 0x0303) → grants alternate 0,1,0,1,...; 8 writes alternate 0x00004 and 0x10009 back-to-back, with no idle cycle.
- Credit backpressure: OUT_DEPTH=4, no OUT_RD, 10 words queued → exactly 4 issues and 4 writes, then stall; one OUT_RD pulse → exactly one more issue.
- STOP: assert STOP one cycle after the 2nd issue → no further RD; the 2 in-flight words still write; deassert STOP → issuing resumes next cycle, continuing round-robin.
- Missing VALID and reset mid-run: force REQ0_VALID=0 for an issued read → no OUT_WR for that slot, ERR=1, credit restored. Then pull RST low during a stream → all outputs 0 on the next edge, credit=OUT_DEPTH, ERR=0.
- Corner product, with ARB_STATS_EN defined: req1 word 0xFFFF → OUT_DOUT=0x1FE01, CNT1 increments by 1, CNT0 unchanged; CNT_CLR asserted on the same cycle as a write → both counters read 0 afterwards.
